// File: rtl/datapath_pkg.sv
// Shared definitions for the 16-bit pipelined datapath: opcodes, the bubble word
// and the fetch-stage FSM state encoding.
package datapath_pkg;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ANDI = 4'h1;
  localparam logic [3:0] OP_ORI  = 4'h2;
  localparam logic [3:0] OP_BGT  = 4'h4;
  localparam logic [3:0] OP_BLT  = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_LBU  = 4'hA;
  localparam logic [3:0] OP_SB   = 4'hB;
  localparam logic [3:0] OP_LW   = 4'hC;
  localparam logic [3:0] OP_SW   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [15:0] INST_NOP = 16'h0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register carrying an instruction word and its next-PC, with
// clear (bubble) taking priority over hold (stall).
module ifid_reg #(
  parameter int INST_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_hold,
  input  logic [INST_W-1:0] i_inst,
  input  logic [PC_W-1:0]   i_pc_next,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_W-1:0]   o_pc_next,
  output logic              o_valid
);

  logic [INST_W-1:0] r_inst;
  logic [PC_W-1:0]   r_pc_next;
  logic              r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst    <= '0;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else if (i_clear) begin
      r_inst    <= '0;
      r_pc_next <= '0;
      r_valid   <= 1'b0;
    end else if (!i_hold) begin
      r_inst    <= i_inst;
      r_pc_next <= i_pc_next;
      r_valid   <= 1'b1;
    end
  end

  assign o_inst    = r_inst;
  assign o_pc_next = r_pc_next;
  assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, feeds IF/ID, and handles stall, branch
// redirect and HALT with a two-state RUN/HALT FSM.
module fetch_unit
  import datapath_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [15:0] ifid_inst,
  output logic [7:0]  ifid_pc_next,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  fetch_state_t r_state, w_state_next;
  logic [7:0]   r_pc, w_pc_next;
  logic [15:0]  r_fetch_count;
  logic         w_ifid_clear, w_ifid_hold, w_count_en;
  logic [7:0]   w_pc_plus2, w_target;
  logic         w_is_halt;
  logic         w_unused_tgt0;

  assign w_pc_plus2    = r_pc + 8'd2;
  assign w_target      = {branch_target[7:1], 1'b0};
  assign w_is_halt     = (imem_data[15:12] == HALT_OP);
  assign w_unused_tgt0 = branch_target[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_pc          <= PC_RESET;
      r_fetch_count <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_count_en) r_fetch_count <= sat_inc16(r_fetch_count);
    end
  end

  // Branch beats stall, stall beats normal fetch; HALT only leaves via branch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ifid_clear = 1'b0;
    w_ifid_hold  = 1'b0;
    w_count_en   = 1'b0;
    if (branch_taken) begin
      w_pc_next    = w_target;
      w_ifid_clear = 1'b1;
      w_state_next = ST_RUN;
    end else if (stall) begin
      w_ifid_hold = 1'b1;
    end else if (r_state == ST_RUN) begin
      w_count_en = 1'b1;
      if (w_is_halt) w_state_next = ST_HALT;
      else           w_pc_next    = w_pc_plus2;
    end else begin
      w_ifid_clear = 1'b1;
    end
  end

  ifid_reg #(
    .INST_W(16),
    .PC_W  (8)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_ifid_clear),
    .i_hold   (w_ifid_hold),
    .i_inst   (imem_data),
    .i_pc_next(w_pc_plus2),
    .o_inst   (ifid_inst),
    .o_pc_next(ifid_pc_next),
    .o_valid  (ifid_valid)
  );

  assign imem_addr   = r_pc;
  assign halted      = (r_state == ST_HALT);
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] ifid_inst;
  logic [7:0]  ifid_pc_next;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:127];
  int n_checks;
  int n_fail;

  fetch_unit #(
    .PC_RESET(8'h00),
    .HALT_OP (4'hF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ifid_inst    (ifid_inst),
    .ifid_pc_next (ifid_pc_next),
    .ifid_valid   (ifid_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  assign imem_data = mem[imem_addr[7:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] pc, input logic [15:0] inst,
                         input logic [7:0] pcn, input logic vld, input logic hlt,
                         input logic [15:0] cnt);
    chk({tag, ".pc"},      {24'h0, imem_addr},    {24'h0, pc});
    chk({tag, ".inst"},    {16'h0, ifid_inst},    {16'h0, inst});
    chk({tag, ".pc_next"}, {24'h0, ifid_pc_next}, {24'h0, pcn});
    chk({tag, ".valid"},   {31'h0, ifid_valid},   {31'h0, vld});
    chk({tag, ".halted"},  {31'h0, halted},       {31'h0, hlt});
    chk({tag, ".count"},   {16'h0, fetch_count},  {16'h0, cnt});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 16'h1000 | 16'(i * 2);
    mem[8'h00 >> 1] = 16'h0E20;
    mem[8'h02 >> 1] = 16'h0B21;
    mem[8'h3E >> 1] = 16'hF000;

    // Reset state
    cyc(2);
    chk_all("reset", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 16'd0);
    rst = 1'b1;

    // Free run from 00
    cyc(1);
    chk_all("run1", 8'h02, 16'h0E20, 8'h02, 1'b1, 1'b0, 16'd1);
    cyc(1);
    chk_all("run2", 8'h04, 16'h0B21, 8'h04, 1'b1, 1'b0, 16'd2);
    cyc(2);
    chk_all("run4", 8'h08, 16'h1006, 8'h08, 1'b1, 1'b0, 16'd4);

    // Stall three edges at pc=08
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk_all("stall", 8'h08, 16'h1006, 8'h08, 1'b1, 1'b0, 16'd4);
    end
    stall = 1'b0;
    cyc(1);
    chk_all("resume1", 8'h0A, 16'h1008, 8'h0A, 1'b1, 1'b0, 16'd5);
    cyc(1);
    chk_all("resume2", 8'h0C, 16'h100A, 8'h0C, 1'b1, 1'b0, 16'd6);

    // Branch with stall in the same cycle at pc=22, odd target
    cyc(11);
    chk_all("pre_br", 8'h22, 16'h1020, 8'h22, 1'b1, 1'b0, 16'd17);
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 8'h2D;
    cyc(1);
    chk_all("br_bubble", 8'h2C, 16'h0000, 8'h00, 1'b0, 1'b0, 16'd17);
    stall = 1'b0;
    branch_taken = 1'b0;
    cyc(1);
    chk_all("br_target", 8'h2E, 16'h102C, 8'h2E, 1'b1, 1'b0, 16'd18);

    // HALT at 3E
    cyc(8);
    chk_all("pre_halt", 8'h3E, 16'h103C, 8'h3E, 1'b1, 1'b0, 16'd26);
    cyc(1);
    chk_all("halt_word", 8'h3E, 16'hF000, 8'h40, 1'b1, 1'b1, 16'd27);
    cyc(1);
    chk_all("halt_bub1", 8'h3E, 16'h0000, 8'h00, 1'b0, 1'b1, 16'd27);
    cyc(1);
    chk_all("halt_bub2", 8'h3E, 16'h0000, 8'h00, 1'b0, 1'b1, 16'd27);

    // Async reset while halted
    #1 rst = 1'b0;
    #1 chk_all("async_rst", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 16'd0);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk_all("restart", 8'h02, 16'h0E20, 8'h02, 1'b1, 1'b0, 16'd1);

    // HALT fetched, branch one cycle later
    mem[8'h06 >> 1] = 16'hF000;
    cyc(3);
    chk_all("halt2", 8'h06, 16'hF000, 8'h08, 1'b1, 1'b1, 16'd4);
    branch_taken = 1'b1;
    branch_target = 8'h30;
    cyc(1);
    chk_all("unhalt", 8'h30, 16'h0000, 8'h00, 1'b0, 1'b0, 16'd4);
    branch_taken = 1'b0;
    cyc(1);
    chk_all("unhalt_run", 8'h32, 16'h1030, 8'h32, 1'b1, 1'b0, 16'd5);

    // PC wrap FE -> 00
    branch_taken = 1'b1;
    branch_target = 8'hFE;
    cyc(1);
    branch_taken = 1'b0;
    chk_all("wrap_br", 8'hFE, 16'h0000, 8'h00, 1'b0, 1'b0, 16'd5);
    cyc(1);
    chk_all("wrap", 8'h00, 16'h10FE, 8'h00, 1'b1, 1'b0, 16'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipelined datapath. Owns the program counter and drives the byte address into instruction memory, which returns a 16-bit word combinationally. Captures each fetched word into the IF/ID pipeline register. Handles stall, branch redirect and HALT detection, and keeps a fetch counter for debug.

## Interface
Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.
- HALT_OP, 4'hF, opcode (inst[15:12]) that stops fetching.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- imem_addr  out  8  instruction memory byte address. Equals the PC register.
- imem_data  in  16  instruction word at imem_addr. Combinational, same cycle.
- stall  in  1  hazard unit request to hold the PC and IF/ID.
- branch_taken  in  1  redirect request from the branch-resolve stage.
- branch_target  in  8  redirect address. Bit 0 is ignored (forced 0).
- ifid_inst  out  16  IF/ID instruction register.
- ifid_pc_next  out  8  IF/ID copy of fetch PC + 2.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  high while the FSM is in HALT.
- fetch_count  out  16  number of instructions loaded into IF/ID, saturating.

## Operation
- FSM has two states: RUN and HALT. Reset enters RUN.
- PC always holds an even address. Increment is +2, modulo 256, so 8'hFE wraps to 8'h00.
- Each rising edge applies the first matching rule below, in priority order.
  1. **branch_taken=1** (any state, regardless of stall):
     - pc <= {branch_target[7:1],1'b0}.
     - IF/ID <= bubble (inst=16'h0000, pc_next=0, valid=0).
     - state <= RUN.
  2. **stall=1**: pc, IF/ID, state and fetch_count all hold.
  3. **RUN**:
     - IF/ID <= {imem_data, pc+2, valid=1}.
     - fetch_count increments, saturating at 16'hFFFF.
     - If imem_data[15:12]==HALT_OP: pc holds and state <= HALT. The HALT word itself is still delivered into IF/ID once.
     - Otherwise pc <= pc+2.
  4. **HALT**: IF/ID <= bubble and pc holds. Only branch_taken leaves HALT. This lets a HALT fetched in a branch shadow be squashed.
- halted = (state==HALT), decoded from registered state.
- Address range is not checked. Addresses beyond the populated memory return whatever memory supplies.

## Timing
- Reset values, applied asynchronously while rst=0:
  - pc=PC_RESET, state=RUN
  - ifid_inst=16'h0000, ifid_pc_next=8'h00, ifid_valid=0
  - halted=0, fetch_count=0
- The first fetch is captured on the first rising edge with rst=1.
- Fetch latency: imem_addr is presented in cycle N. The word appears on ifid_inst after edge N+1.
- Branch penalty: exactly one bubble in IF/ID from this block. Squashing older stages is the hazard unit's job.
- Redirect: the target word is addressed in the cycle after branch_taken and captured one edge later.
- Stall deasserting: fetch resumes at the held pc with no lost or duplicated word.
- rst asserted mid-operation, including in HALT: all state returns to reset values immediately.

## Structure
- Shared package `datapath_pkg`: opcode constants (ALU=4'h0, ANDI=4'h1, ORI=4'h2, BGT=4'h4, BLT=4'h5, BEQ=4'h6, LBU=4'hA, SB=4'hB, LW=4'hC, SW=4'hD, HALT=4'hF), NOP/bubble word 16'h0000, and the fetch FSM state enum.
- Sub-module: `ifid_reg`, the IF/ID register with hold (stall) and clear (bubble) controls, reused by later pipeline-register stages.

## Test plan
- Reset then free run, memory 0x00=16'h0E20, 0x02=16'h0B21:
  - imem_addr sequence 00, 02, 04.
  - ifid_inst 0E20 then 0B21, ifid_pc_next 02 then 04, ifid_valid=1.
- HALT at 0x3E (16'hF000):
  - ifid_inst=F000 once, then bubbles.
  - pc stays 3E, halted=1.
  - fetch_count stops incrementing.
- stall high for 3 cycles at pc=08: pc, IF/ID and fetch_count hold for 3 edges, then resume with word at 08, no duplicate.
- branch_taken with target 8'h2D at pc=22, same cycle as stall=1:
  - branch wins, pc=2C, one bubble.
  - next capture is mem[2C].
- HALT fetched, then branch_taken target 30 one cycle later: halted drops to 0, fetch resumes at 30.
- rst pulsed low while halted at 3E: outputs return to reset values asynchronously, and fetch restarts at 00.
